wb_uart_rx: RTL

Serial 8N1 UART receiver with a receive FIFO, exposed as a Wishbone B3 slave. It samples the `rx` line from an external UART transmitter, such as `wb_uart_wrapper` looped back in simulation. Received bytes are buffered so the CPU can poll or take an interrupt. It sits on the Wishbone interconnect as an ordinary slave alongside main RAM and the UART transmitter.

---
 rtl/wb_uart_rx_pkg.sv | 38 +++
 rtl/uart_rx_fifo.sv | 49 ++++
 rtl/wb_uart_rx.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_uart_rx_pkg.sv
// Shared constants, register map and receiver state encoding for the
// Wishbone UART receiver.
package wb_uart_rx_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned DIV_W  = 16;
  localparam int unsigned WB_DW  = 32;

  // Word offsets decoded from wb_adr_i[3:2]
  localparam logic [1:0] REG_RXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVISOR = 2'd2;
  localparam logic [1:0] REG_IRQ_EN  = 2'd3;

  localparam int unsigned ST_NOT_EMPTY = 0;
  localparam int unsigned ST_FULL      = 1;
  localparam int unsigned ST_OVERRUN   = 2;
  localparam int unsigned ST_FRAME_ERR = 3;
  localparam int unsigned ST_COUNT_LSB = 8;

  localparam int unsigned IE_NOT_EMPTY = 0;
  localparam int unsigned IE_OVERRUN   = 1;
  localparam int unsigned IE_FRAME_ERR = 2;

  typedef enum logic [2:0] {
    RX_IDLE  = 3'd0,
    RX_START = 3'd1,
    RX_DATA  = 3'd2,
    RX_STOP  = 3'd3,
    RX_BREAK = 3'd4
  } rx_state_e;

  // A programmed divisor of zero runs at the fastest rate rather than stalling.
  function automatic logic [DIV_W-1:0] eff_divisor(input logic [DIV_W-1:0] d);
    return (d == '0) ? DIV_W'(1) : d;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous byte FIFO; the extra pointer MSB separates full from empty.
module uart_rx_fifo
  import wb_uart_rx_pkg::*;
#(
  parameter int unsigned AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              empty,
  output logic              full,
  output logic [AW:0]       count
);

  localparam int unsigned DEPTH = 1 << AW;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wptr;
  logic [AW:0]       rptr;
  logic              do_push;
  logic              do_pop;

  assign count = wptr - rptr;
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign dout  = mem[rptr[AW-1:0]];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + (AW+1)'(1);
      if (do_pop)  rptr <= rptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/wb_uart_rx.sv
// 8N1 UART receiver with 16x oversampling, a receive FIFO and a Wishbone
// B3 classic slave register interface.
module wb_uart_rx
  import wb_uart_rx_pkg::*;
#(
  parameter int unsigned      FIFO_AW     = 4,
  parameter logic [DIV_W-1:0] DIVISOR_RST = 16'd26
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             rx,
  input  logic [31:0]      wb_adr_i,
  input  logic [WB_DW-1:0] wb_dat_i,
  input  logic [3:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_cyc_i,
  input  logic             wb_stb_i,
  input  logic [2:0]       wb_cti_i,
  input  logic [1:0]       wb_bte_i,
  output logic [WB_DW-1:0] wb_dat_o,
  output logic             wb_ack_o,
  output logic             wb_err_o,
  output logic             wb_rty_o,
  output logic             irq_o
);

  logic              rx_meta;
  logic              rx_sync;
  logic [DIV_W-1:0]  divisor;
  logic [DIV_W-1:0]  div_eff;
  logic [DIV_W-1:0]  presc;
  logic              tick;

  rx_state_e         state;
  rx_state_e         state_n;
  logic [3:0]        tick_cnt;
  logic [3:0]        tick_cnt_n;
  logic [2:0]        bit_idx;
  logic [2:0]        bit_idx_n;
  logic [DATA_W-1:0] shift;
  logic [DATA_W-1:0] shift_n;
  logic              restart;
  logic              push_set;
  logic              frame_set;

  logic              push_q;
  logic [DATA_W-1:0] push_byte;
  logic [2:0]        irq_en;
  logic              overrun;
  logic              frame_err;
  logic              pop_ok;

  logic              req;
  logic              wr_commit;
  logic              fifo_pop;
  logic [1:0]        reg_sel;
  logic [WB_DW-1:0]  rd_mux;

  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              fifo_full;
  logic [FIFO_AW:0]  fifo_count;

  logic              unused_inputs;

  assign unused_inputs = ^{wb_adr_i[31:4], wb_adr_i[1:0], wb_dat_i[31:16],
                           wb_sel_i[3:2], wb_cti_i, wb_bte_i};

  assign wb_err_o = 1'b0;
  assign wb_rty_o = 1'b0;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  // 1/16-bit prescaler; realigned to the detected start edge.
  assign div_eff = eff_divisor(divisor);
  assign tick    = (presc <= DIV_W'(1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i)             presc <= DIVISOR_RST;
    else if (restart || tick) presc <= div_eff;
    else                      presc <= presc - DIV_W'(1);
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state    <= RX_IDLE;
      tick_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_cnt_n;
      bit_idx  <= bit_idx_n;
      shift    <= shift_n;
    end
  end

  always_comb begin
    state_n    = state;
    tick_cnt_n = tick_cnt;
    bit_idx_n  = bit_idx;
    shift_n    = shift;
    restart    = 1'b0;
    push_set   = 1'b0;
    frame_set  = 1'b0;
    case (state)
      RX_IDLE: begin
        if (!rx_sync) begin
          state_n    = RX_START;
          tick_cnt_n = '0;
          bit_idx_n  = '0;
          restart    = 1'b1;
        end
      end
      RX_START: begin
        if (tick) begin
          tick_cnt_n = tick_cnt + 4'(1);
          if (tick_cnt == 4'd7) begin
            tick_cnt_n = '0;
            state_n    = rx_sync ? RX_IDLE : RX_DATA;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          tick_cnt_n = tick_cnt + 4'(1);
          if (tick_cnt == 4'd15) begin
            shift_n   = {rx_sync, shift[DATA_W-1:1]};
            bit_idx_n = bit_idx + 3'(1);
            if (bit_idx == 3'd7) state_n = RX_STOP;
          end
        end
      end
      RX_STOP: begin
        if (tick) begin
          tick_cnt_n = tick_cnt + 4'(1);
          if (tick_cnt == 4'd15) begin
            if (rx_sync) begin
              push_set = 1'b1;
              state_n  = RX_IDLE;
            end else begin
              frame_set = 1'b1;
              state_n   = RX_BREAK;
            end
          end
        end
      end
      RX_BREAK: begin
        if (rx_sync) state_n = RX_IDLE;
      end
      default: state_n = RX_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      push_q    <= 1'b0;
      push_byte <= '0;
    end else begin
      push_q <= push_set;
      if (push_set) push_byte <= shift;
    end
  end

  uart_rx_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk   (wb_clk_i),
    .rst   (wb_rst_i),
    .push  (push_q),
    .pop   (fifo_pop),
    .din   (push_byte),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

  assign req       = wb_cyc_i & wb_stb_i;
  assign reg_sel   = wb_adr_i[3:2];
  assign wr_commit = req & wb_ack_o & wb_we_i;
  assign fifo_pop  = req & wb_ack_o & pop_ok;

  always_comb begin
    rd_mux = '0;
    case (reg_sel)
      REG_RXDATA: rd_mux = fifo_empty ? '0 : WB_DW'(fifo_dout);
      REG_STATUS: begin
        rd_mux[ST_NOT_EMPTY]         = ~fifo_empty;
        rd_mux[ST_FULL]              = fifo_full;
        rd_mux[ST_OVERRUN]           = overrun;
        rd_mux[ST_FRAME_ERR]         = frame_err;
        rd_mux[ST_COUNT_LSB +: 8]    = 8'(fifo_count);
      end
      REG_DIVISOR: rd_mux = WB_DW'(divisor);
      default:     rd_mux = WB_DW'(irq_en);
    endcase
  end

  // Read data is captured with the ack; the pop is armed only if data was returned.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      pop_ok   <= 1'b0;
    end else begin
      wb_ack_o <= req & ~wb_ack_o;
      wb_dat_o <= (req & ~wb_ack_o & ~wb_we_i) ? rd_mux : '0;
      pop_ok   <= req & ~wb_ack_o & ~wb_we_i & (reg_sel == REG_RXDATA) & ~fifo_empty;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      divisor   <= DIVISOR_RST;
      irq_en    <= '0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (wr_commit && reg_sel == REG_DIVISOR) begin
        if (wb_sel_i[0]) divisor[7:0]  <= wb_dat_i[7:0];
        if (wb_sel_i[1]) divisor[15:8] <= wb_dat_i[15:8];
      end
      if (wr_commit && reg_sel == REG_IRQ_EN) irq_en <= wb_dat_i[2:0];
      // New error events win over a simultaneous W1C
      if (push_q && fifo_full && !fifo_pop)
        overrun <= 1'b1;
      else if (wr_commit && reg_sel == REG_STATUS && wb_dat_i[ST_OVERRUN])
        overrun <= 1'b0;
      if (frame_set)
        frame_err <= 1'b1;
      else if (wr_commit && reg_sel == REG_STATUS && wb_dat_i[ST_FRAME_ERR])
        frame_err <= 1'b0;
    end
  end

  assign irq_o = |(irq_en & {frame_err, overrun, ~fifo_empty});

endmodule
